// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory read handshake and holds the IR.
// Optional macro FETCH_TIMEOUT_EN aborts a stalled read after TIMEOUT request cycles and flags FETCH_ERR.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h0001000,
  parameter int TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FETCH_START,
  input  logic                  PC_LOAD,
  input  logic [ADDR_WIDTH-1:0] PC_NEXT,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  input  logic                  MEM_READY,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic                  IR_VALID,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PC_PLUS1,
  output logic                  BUSY,
  output logic                  FETCH_ERR
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic                  pend_valid;
  logic                  timeout_hit;
  logic                  req_exit;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] count;
  logic       fetch_err;

  assign timeout_hit = !MEM_READY && (count == 4'(TIMEOUT - 1));
  assign FETCH_ERR   = fetch_err;

  // Counts request cycles that passed without read data; cleared whenever a read starts or ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count     <= '0;
      fetch_err <= 1'b0;
    end else if (state == REQ) begin
      if (req_exit) begin
        count     <= '0;
        fetch_err <= timeout_hit;
      end else begin
        count <= count + 4'd1;
      end
    end else if (FETCH_START) begin
      count     <= '0;
      fetch_err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign FETCH_ERR   = 1'b0;
`endif

  assign req_exit = MEM_READY || timeout_hit;
  assign MEM_ADDR = pc;
  assign PC       = pc;
  assign PC_PLUS1 = pc + ADDR_WIDTH'(1);

  // A PC load during a read is parked so MEM_ADDR stays stable; a load on the exit edge itself wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      pend_valid  <= 1'b0;
      INSTRUCTION <= '0;
      IR_VALID    <= 1'b0;
      MEM_READ    <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (PC_LOAD) pc <= PC_NEXT;
          if (FETCH_START) begin
            state      <= REQ;
            MEM_READ   <= 1'b1;
            BUSY       <= 1'b1;
            IR_VALID   <= 1'b0;
            pend_valid <= 1'b0;
          end
        end
        REQ: begin
          if (req_exit) begin
            state       <= HOLD;
            INSTRUCTION <= MEM_READY ? MEM_DATA : '0;
            IR_VALID    <= 1'b1;
            MEM_READ    <= 1'b0;
            BUSY        <= 1'b0;
            pend_valid  <= 1'b0;
            if (PC_LOAD) pc <= PC_NEXT;
            else if (pend_valid) pc <= pend_pc;
          end else if (PC_LOAD) begin
            pend_pc    <= PC_NEXT;
            pend_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run against a fetch model.
// Define FETCH_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FETCH_START = 1'b0;
  logic        PC_LOAD = 1'b0;
  logic [25:0] PC_NEXT = '0;
  logic [25:0] MEM_ADDR;
  logic        MEM_READ;
  logic [31:0] MEM_DATA = '0;
  logic        MEM_READY = 1'b0;
  logic [31:0] INSTRUCTION;
  logic        IR_VALID;
  logic [25:0] PC;
  logic [25:0] PC_PLUS1;
  logic        BUSY;
  logic        FETCH_ERR;

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_unit dut (
    .CLK(CLK), .RST(RST), .FETCH_START(FETCH_START), .PC_LOAD(PC_LOAD), .PC_NEXT(PC_NEXT),
    .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .INSTRUCTION(INSTRUCTION), .IR_VALID(IR_VALID), .PC(PC), .PC_PLUS1(PC_PLUS1),
    .BUSY(BUSY), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: a fetch is either in flight or not; waited counts stalled request cycles.
  int          m_pc;
  logic [31:0] m_ir;
  bit          m_irv, m_err, m_fetching, m_pend;
  int          m_pend_pc, m_waited;

  task automatic model_reset();
    m_pc = 'h1000; m_ir = '0; m_irv = 0; m_err = 0;
    m_fetching = 0; m_pend = 0; m_pend_pc = 0; m_waited = 0;
  endtask

  task automatic model_edge(input bit start, input bit load, input int next, input bit ready, input logic [31:0] data);
    if (!m_fetching) begin
      if (load) m_pc = next;
      if (start) begin
        m_fetching = 1; m_irv = 0; m_err = 0; m_waited = 0;
      end
    end else begin
      if (load) begin
        m_pend = 1; m_pend_pc = next;
      end
      if (ready) begin
        m_ir = data; m_irv = 1; m_fetching = 0;
      end else begin
        m_waited++;
`ifdef FETCH_TIMEOUT_EN
        if (m_waited == 15) begin
          m_ir = 0; m_irv = 1; m_err = 1; m_fetching = 0;
        end
`endif
      end
      if (!m_fetching && m_pend) begin
        m_pc = m_pend_pc; m_pend = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    FETCH_START = 0; PC_LOAD = 0; MEM_READY = 0; PC_NEXT = '0; MEM_DATA = '0;
    @(negedge CLK);
    RST = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (PC !== 26'h0001000) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected 0001000", PC); end
    tests_run++;
    if (MEM_ADDR !== 26'h0001000) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h expected 0001000", MEM_ADDR); end
    tests_run++;
    if (PC_PLUS1 !== 26'h0001001) begin tests_failed++; $display("[TB] FAIL reset_pc_plus1: got %h expected 0001001", PC_PLUS1); end
    tests_run++;
    if ({IR_VALID, MEM_READ, BUSY, FETCH_ERR} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got irv/rd/busy/err=%b expected 0000", {IR_VALID, MEM_READ, BUSY, FETCH_ERR});
    end
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (INSTRUCTION !== 32'h0) begin tests_failed++; $display("[TB] FAIL idle_ir cycle %0d: got %h expected 0", i, INSTRUCTION); end
      tick();
    end
  endtask

  task automatic test_zero_wait();
    FETCH_START = 1;
    tick();
    FETCH_START = 0; MEM_READY = 1; MEM_DATA = 32'h00430820;
    tests_run++;
    if ({MEM_READ, BUSY, IR_VALID} !== 3'b110) begin
      tests_failed++; $display("[TB] FAIL zw_req: got rd/busy/irv=%b expected 110", {MEM_READ, BUSY, IR_VALID});
    end
    tick();
    MEM_READY = 0;
    tests_run++;
    if ({MEM_READ, BUSY, IR_VALID} !== 3'b001) begin
      tests_failed++; $display("[TB] FAIL zw_done: got rd/busy/irv=%b expected 001", {MEM_READ, BUSY, IR_VALID});
    end
    tests_run++;
    if (INSTRUCTION !== 32'h00430820) begin tests_failed++; $display("[TB] FAIL zw_ir: got %h expected 00430820", INSTRUCTION); end
    tick();
    tests_run++;
    if (MEM_READ !== 1'b0) begin tests_failed++; $display("[TB] FAIL zw_read_once: got %b expected 0", MEM_READ); end
  endtask

  task automatic test_ready_outside_req();
    MEM_READY = 1; MEM_DATA = 32'hDEADBEEF;
    repeat (3) tick();
    MEM_READY = 0;
    tests_run++;
    if (INSTRUCTION !== 32'h00430820 || IR_VALID !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL hold_ignore_ready: got ir=%h irv=%b expected 00430820 1", INSTRUCTION, IR_VALID);
    end
  endtask

  task automatic test_wait_and_load();
    logic [31:0] data;
    data = $urandom;
    FETCH_START = 1;
    tick();
    FETCH_START = 0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (MEM_ADDR !== 26'h0001000 || PC !== 26'h0001000 || MEM_READ !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL wait_addr_stable cycle %0d: got addr=%h pc=%h rd=%b expected 0001000 0001000 1", i, MEM_ADDR, PC, MEM_READ);
      end
      PC_LOAD = (i == 1); PC_NEXT = 26'h0002000;
      MEM_READY = (i == 3); MEM_DATA = data;
      tick();
    end
    PC_LOAD = 0; MEM_READY = 0;
    tests_run++;
    if (PC !== 26'h0002000) begin tests_failed++; $display("[TB] FAIL wait_pending_pc: got %h expected 0002000", PC); end
    tests_run++;
    if (INSTRUCTION !== data || IR_VALID !== 1'b1 || MEM_READ !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL wait_done: got ir=%h irv=%b rd=%b expected %h 1 0", INSTRUCTION, IR_VALID, MEM_READ, data);
    end
  endtask

  task automatic test_load_and_start();
    PC_LOAD = 1; PC_NEXT = 26'h3FFFFFF; FETCH_START = 1;
    tick();
    PC_LOAD = 0; FETCH_START = 0;
    tests_run++;
    if (MEM_ADDR !== 26'h3FFFFFF || MEM_READ !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ls_addr: got addr=%h rd=%b expected 3ffffff 1", MEM_ADDR, MEM_READ);
    end
    tests_run++;
    if (PC_PLUS1 !== 26'h0000000) begin tests_failed++; $display("[TB] FAIL ls_wrap: got %h expected 0000000", PC_PLUS1); end
    MEM_READY = 1; MEM_DATA = 32'h12345678;
    tick();
    MEM_READY = 0;
    tests_run++;
    if (INSTRUCTION !== 32'h12345678 || PC !== 26'h3FFFFFF) begin
      tests_failed++; $display("[TB] FAIL ls_done: got ir=%h pc=%h expected 12345678 3ffffff", INSTRUCTION, PC);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    FETCH_START = 1;
    tick();
    FETCH_START = 0;
    for (int i = 1; i < 15; i++) begin
      tick();
      tests_run++;
      if (MEM_READ !== 1'b1 || FETCH_ERR !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL to_early cycle %0d: got rd=%b err=%b expected 1 0", i, MEM_READ, FETCH_ERR);
      end
    end
    tick();
    tests_run++;
    if ({FETCH_ERR, IR_VALID, MEM_READ, BUSY} !== 4'b1100 || INSTRUCTION !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL to_abort: got err/irv/rd/busy=%b ir=%h expected 1100 0", {FETCH_ERR, IR_VALID, MEM_READ, BUSY}, INSTRUCTION);
    end
    repeat (3) tick();
    tests_run++;
    if (FETCH_ERR !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_sticky: got %b expected 1", FETCH_ERR); end
    FETCH_START = 1;
    tick();
    FETCH_START = 0;
    tests_run++;
    if (FETCH_ERR !== 1'b0 || IR_VALID !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL to_clear: got err=%b irv=%b expected 0 0", FETCH_ERR, IR_VALID);
    end
    MEM_READY = 1;
    tick();
    MEM_READY = 0;
  endtask
`endif

  task automatic test_reset_mid_fetch();
    FETCH_START = 1;
    tick();
    FETCH_START = 0;
    tests_run++;
    if (MEM_READ !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmf_in_req: got %b expected 1", MEM_READ); end
    #2;
    RST = 0;
    #1;
    tests_run++;
    if ({MEM_READ, IR_VALID, BUSY} !== 3'b000 || PC !== 26'h0001000) begin
      tests_failed++; $display("[TB] FAIL rmf_async: got rd/irv/busy=%b pc=%h expected 000 0001000", {MEM_READ, IR_VALID, BUSY}, PC);
    end
    @(negedge CLK);
    RST = 1;
    tick();
  endtask

  task automatic test_random();
    bit s, l, r;
    int n;
    logic [31:0] d;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      s = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) == 0);
      n = ($urandom_range(0, 7) == 0) ? 'h3FFFFFF : int'($urandom_range(0, 'h3FFFFFF));
      d = $urandom;
      FETCH_START = s; PC_LOAD = l; PC_NEXT = 26'(n); MEM_READY = r; MEM_DATA = d;
      tick();
      model_edge(s, l, n, r, d);
      tests_run++;
      if (PC !== 26'(m_pc) || MEM_ADDR !== 26'(m_pc)) begin
        tests_failed++; $display("[TB] FAIL rnd_pc cycle %0d: got pc=%h addr=%h expected %h", c, PC, MEM_ADDR, 26'(m_pc));
      end
      tests_run++;
      if (PC_PLUS1 !== 26'((m_pc + 1) % 67108864)) begin
        tests_failed++; $display("[TB] FAIL rnd_pc_plus1 cycle %0d: got %h expected %h", c, PC_PLUS1, 26'((m_pc + 1) % 67108864));
      end
      tests_run++;
      if (MEM_READ !== m_fetching || BUSY !== m_fetching) begin
        tests_failed++; $display("[TB] FAIL rnd_busy cycle %0d: got rd=%b busy=%b expected %b", c, MEM_READ, BUSY, m_fetching);
      end
      tests_run++;
      if (IR_VALID !== m_irv || INSTRUCTION !== m_ir || FETCH_ERR !== m_err) begin
        tests_failed++; $display("[TB] FAIL rnd_ir cycle %0d: got irv=%b ir=%h err=%b expected %b %h %b", c, IR_VALID, INSTRUCTION, FETCH_ERR, m_irv, m_ir, m_err);
      end
    end
    FETCH_START = 0; PC_LOAD = 0; MEM_READY = 0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ready_outside_req();
    test_wait_and_load();
    test_load_and_start();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
